rle_row_decompressor: RTL and testbench

Run-length decoder that sits directly upstream of the DMA stage in the IO module. It accepts a stream of compressed run tokens, rebuilds one uncompressed row of `ROW_SIZE` bits at a time, and presents the row on `decompressedRow`. The row is held stable until the downstream DMA stage accepts it. Runs may span row boundaries, and a final partial row is zero-padded.

---
 rtl/rle_row_decompressor.sv | 129 ++++++++++++
 tb/tb_rle_row_decompressor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rle_row_decompressor.sv
// rle_row_decompressor: run-length token decoder that assembles ROW_SIZE-bit rows for the DMA stage.
// Optional macro RLE_DECOMP_ERR_EN enables sticky protocol error detection on err.
module rle_row_decompressor #(
  parameter int ROW_SIZE  = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CNT_WIDTH:0]  in_data,
  input  logic                in_last,
  output logic [ROW_SIZE-1:0] decompressedRow,
  output logic                row_valid,
  input  logic                row_ready,
  output logic                row_last,
  output logic                busy,
  output logic                err
);
  localparam int PW = $clog2(ROW_SIZE + 1);
  localparam int AW = (CNT_WIDTH > PW ? CNT_WIDTH : PW) + 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t                 state_q, state_d;
  logic [ROW_SIZE-1:0]    row_q, row_d, mask;
  logic [PW-1:0]          pos_q, pos_d;
  logic [CNT_WIDTH-1:0]   run_left_q, run_left_d;
  logic                   run_val_q, run_val_d, have_run_q, have_run_d;
  logic                   last_pend_q, last_pend_d, row_valid_q, row_valid_d, row_last_q, row_last_d;
  logic [AW-1:0]          pos_a, avail, run_a, k, end_a;
  logic                   accept;
  assign in_ready = state_q == FILL && !have_run_q && !rst;
  assign accept   = in_valid && in_ready;
  assign pos_a    = AW'(pos_q);
  assign avail    = AW'(ROW_SIZE) - pos_a;
  assign run_a    = AW'(run_left_q);
  assign k        = run_a < avail ? run_a : avail;
  assign end_a    = pos_a + k;
  // bits [pos, pos+k); a shift by ROW_SIZE yields all zeros, so a full-row write still works
  assign mask     = ({ROW_SIZE{1'b1}} << pos_q) & ~({ROW_SIZE{1'b1}} << end_a);
  assign decompressedRow = row_q;
  assign row_valid       = row_valid_q;
  assign row_last        = row_last_q;
  assign busy            = have_run_q || pos_q != '0 || state_q == HOLD;
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pos_d       = pos_q;
    run_left_d  = run_left_q;
    run_val_d   = run_val_q;
    have_run_d  = have_run_q;
    last_pend_d = last_pend_q;
    row_valid_d = row_valid_q;
    row_last_d  = row_last_q;
    if (state_q == HOLD) begin
      if (row_ready) begin
        state_d     = FILL;
        row_d       = '0;
        pos_d       = '0;
        row_valid_d = 1'b0;
        row_last_d  = 1'b0;
      end
    end else if (have_run_q) begin
      row_d      = run_val_q ? row_q | mask : row_q & ~mask;
      pos_d      = PW'(end_a);
      run_left_d = CNT_WIDTH'(run_a - k);
      have_run_d = run_a != k;
      if (end_a == AW'(ROW_SIZE)) begin
        state_d     = HOLD;
        row_valid_d = 1'b1;
        row_last_d  = last_pend_q && run_a == k;
        last_pend_d = last_pend_q && run_a != k;
      end
    end else if (last_pend_q) begin
      // last_pend is retired here rather than at the handshake so a token accepted now owns it
      last_pend_d = 1'b0;
      if (pos_q != '0) begin
        state_d     = HOLD;
        row_d       = row_q & ~({ROW_SIZE{1'b1}} << pos_q);
        row_valid_d = 1'b1;
        row_last_d  = 1'b1;
      end
    end
    if (accept) begin
      run_val_d   = in_data[CNT_WIDTH];
      run_left_d  = in_data[CNT_WIDTH-1:0];
      have_run_d  = |in_data[CNT_WIDTH-1:0];
      last_pend_d = in_last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      row_q       <= '0;
      pos_q       <= '0;
      run_left_q  <= '0;
      run_val_q   <= 1'b0;
      have_run_q  <= 1'b0;
      last_pend_q <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pos_q       <= pos_d;
      run_left_q  <= run_left_d;
      run_val_q   <= run_val_d;
      have_run_q  <= have_run_d;
      last_pend_q <= last_pend_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
    end
  end
`ifdef RLE_DECOMP_ERR_EN
  logic err_q, tok_seen_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      tok_seen_q <= 1'b0;
    end else begin
      if (accept && (in_data[CNT_WIDTH-1:0] == '0 || (in_last && !busy && !tok_seen_q))) err_q <= 1'b1;
      if (state_q == HOLD && row_ready && row_last_q) tok_seen_q <= 1'b0;
      else if (accept) tok_seen_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rle_row_decompressor.sv
// tb_rle_row_decompressor: scoreboard bench for rle_row_decompressor (ROW_SIZE=16, CNT_WIDTH=5).
module tb_rle_row_decompressor;
`ifdef RLE_DECOMP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic        clk = 0, rst = 1, in_valid = 0, in_last = 0, row_ready = 0;
  logic [5:0]  in_data = '0;
  logic        in_ready, row_valid, row_last, busy, err;
  logic [15:0] decompressedRow;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int          errors = 0, checks = 0, hs = 0, hs0;

  rle_row_decompressor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .decompressedRow(decompressedRow), .row_valid(row_valid),
    .row_ready(row_ready), .row_last(row_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && row_valid && row_ready) begin
      hs++;
      if (exp_q.size() == 0) check("unexpected_row", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("row", decompressedRow, mon_e[15:0]);
        check("row_last", row_last, mon_e[16]);
      end
    end
  end

  task automatic send(input logic v, input int len, input logic last);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1;
    in_data  = {v, 5'(len)};
    in_last  = last;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 300) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row"}, decompressedRow, 0);
    check({tag, "_valid"}, row_valid, 0);
    check({tag, "_last"}, row_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // basic three-token row
    row_ready = 1;
    exp_q.push_back({1'b0, 16'hF00F});
    send(1, 4, 0);
    send(0, 8, 0);
    send(1, 4, 0);
    drain();
    check("t1_busy", busy, 0);

    // run crossing a row boundary, final row with last
    hs0 = hs;
    exp_q.push_back({1'b0, 16'hFFFF});
    exp_q.push_back({1'b1, 16'h000F});
    send(1, 20, 0);
    send(0, 12, 1);
    drain();
    check("t2_handshakes", hs - hs0, 2);
    check("t2_busy", busy, 0);

    // backpressure with a token waiting upstream
    @(posedge clk);
    #1 row_ready = 0;
    exp_q.push_back({1'b0, 16'hFFFF});
    exp_q.push_back({1'b0, 16'hFF00});
    send(1, 16, 0);
    fork
      send(0, 8, 0);
      begin
        for (int t = 0; t < 20 && !row_valid; t++) @(negedge clk);
        check("hold_valid", row_valid, 1);
        repeat (5) begin
          @(negedge clk);
          check("hold_row", decompressedRow, 16'hFFFF);
          check("hold_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 row_ready = 1;
      end
    join
    send(1, 8, 0);
    drain();
    check("t3_busy", busy, 0);

    // short last token: write then one pad cycle
    @(posedge clk);
    #1 row_ready = 0;
    exp_q.push_back({1'b1, 16'h0007});
    send(1, 3, 1);
    @(negedge clk);
    check("pad_c0_valid", row_valid, 0);
    @(negedge clk);
    check("pad_c1_valid", row_valid, 0);
    check("pad_c1_busy", busy, 1);
    @(negedge clk);
    check("pad_c2_valid", row_valid, 1);
    check("pad_c2_last", row_last, 1);
    check("pad_c2_row", decompressedRow, 16'h0007);
    @(posedge clk);
    #1 row_ready = 1;
    drain();
    check("t4_busy", busy, 0);

    // reset discards a pending run
    send(1, 5, 0);
    rst = 1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_ready", in_ready, 1);
    exp_q.push_back({1'b0, 16'h0000});
    send(0, 16, 0);
    drain();

    // zero-length token
    send(1, 0, 0);
    @(negedge clk);
    check("zl_err", err, ERR_EN);
    check("zl_busy", busy, 0);
    exp_q.push_back({1'b0, 16'hFFFF});
    send(1, 16, 0);
    drain();
    check("zl_err_sticky", err, ERR_EN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end
endmodule
